// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register of the 5-stage MIPS pipeline.
// Ports: clk/reset, hazard stall, D-stage next-PC controls (npc_sel,
// branch_taken, rs_fwd), instruction ROM (imem_addr/imem_rdata), current
// pc, F/D register outputs (fd_ir, fd_pc4, fd_pc8) and fetch_cnt.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [1:0]         npc_sel,
    input  logic               branch_taken,
    input  logic [31:0]        rs_fwd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        fd_ir,
    output logic [31:0]        fd_pc4,
    output logic [31:0]        fd_pc8,
    output logic [31:0]        fetch_cnt
);

    localparam logic [IMEM_AW-1:0] BASE_W = PC_RESET[IMEM_AW+1:2];

    logic [31:0] seq;
    logic [31:0] pc8;
    logic [31:0] br;
    logic [31:0] jt;
    logic [31:0] npc;

    // Word-granular subtraction: the base is word aligned, so the low
    // pc bits never borrow into the index and can be dropped up front.
    assign imem_addr = pc[IMEM_AW+1:2] - BASE_W;

    assign seq = pc + 32'd4;
    assign pc8 = pc + 32'd8;
    assign br  = fd_pc4 + {{14{fd_ir[15]}}, fd_ir[15:0], 2'b00};
    assign jt  = {fd_pc4[31:28], fd_ir[25:0], 2'b00};

    always_comb begin
        npc = seq;
        case (npc_sel)
            2'b00:   npc = seq;
            2'b01:   npc = branch_taken ? br : seq;
            2'b10:   npc = jt;
            2'b11:   npc = rs_fwd;
            default: npc = seq;
        endcase
    end

    // Stall freezes everything; the D-stage transfer is simply
    // re-evaluated once the stall drops, so no redirect is remembered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= PC_RESET;
            fd_ir     <= 32'd0;
            fd_pc4    <= 32'd0;
            fd_pc8    <= 32'd0;
            fetch_cnt <= 32'd0;
        end else if (!stall) begin
            pc        <= npc;
            fd_ir     <= imem_rdata;
            fd_pc4    <= seq;
            fd_pc8    <= pc8;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven sequential/branch
// vectors plus directed jump, stall, jr, wrap and async-reset sequences.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [31:0] rs_fwd;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] fd_ir;
    logic [31:0] fd_pc4;
    logic [31:0] fd_pc8;
    logic [31:0] fetch_cnt;

    logic [31:0] rom [1024];

    int n_chk;
    int n_fail;

    typedef struct {
        logic        stall;
        logic [1:0]  sel;
        logic        bt;
        logic [31:0] rs;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [31:0] cnt;
    } vec_t;

    vec_t tv [8];

    localparam logic [31:0] W0  = 32'h2001_0001;
    localparam logic [31:0] BEQ = 32'h1000_FFFF;
    localparam logic [31:0] W2  = 32'h2002_0002;
    localparam logic [31:0] W3  = 32'h2003_0003;
    localparam logic [31:0] JMP = 32'h0800_0C10;
    localparam logic [31:0] W10 = 32'h2010_0010;
    localparam logic [31:0] W40 = 32'h2040_0040;

    fetch_stage #(
        .PC_RESET(32'h0000_3000),
        .IMEM_AW (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_sel     (npc_sel),
        .branch_taken(branch_taken),
        .rs_fwd      (rs_fwd),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .fd_ir       (fd_ir),
        .fd_pc4      (fd_pc4),
        .fd_pc8      (fd_pc8),
        .fetch_cnt   (fetch_cnt)
    );

    assign imem_rdata = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_ir, input logic [31:0] e_pc4,
                           input logic [31:0] e_pc8, input logic [31:0] e_cnt);
        chk({tag, " pc"}, pc, e_pc);
        chk({tag, " fd_ir"}, fd_ir, e_ir);
        chk({tag, " fd_pc4"}, fd_pc4, e_pc4);
        chk({tag, " fd_pc8"}, fd_pc8, e_pc8);
        chk({tag, " fetch_cnt"}, fetch_cnt, e_cnt);
    endtask

    task automatic drive(input logic s, input logic [1:0] sel,
                         input logic bt, input logic [31:0] rs);
        stall        = s;
        npc_sel      = sel;
        branch_taken = bt;
        rs_fwd       = rs;
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'hDEAD_0000 | i;
        rom[0]    = W0;
        rom[1]    = BEQ;
        rom[2]    = W2;
        rom[3]    = W3;
        rom[10'h10] = W10;
        rom[10'h40] = W40;

        // stall, sel, bt, rs, pc, ir, pc4, pc8, cnt
        tv[0] = '{0, 2'b00, 0, 0, 32'h3004, W0,  32'h3004, 32'h3008, 1};
        tv[1] = '{0, 2'b00, 0, 0, 32'h3008, BEQ, 32'h3008, 32'h300C, 2};
        tv[2] = '{0, 2'b01, 1, 0, 32'h3004, W2,  32'h300C, 32'h3010, 3};
        tv[3] = '{0, 2'b00, 0, 0, 32'h3008, BEQ, 32'h3008, 32'h300C, 4};
        tv[4] = '{0, 2'b01, 0, 0, 32'h300C, W2,  32'h300C, 32'h3010, 5};
        tv[5] = '{0, 2'b00, 0, 0, 32'h3010, W3,  32'h3010, 32'h3014, 6};
        tv[6] = '{1, 2'b01, 1, 0, 32'h3010, W3,  32'h3010, 32'h3014, 6};
        tv[7] = '{1, 2'b11, 0, 32'h5000,
                  32'h3010, W3, 32'h3010, 32'h3014, 6};

        reset = 1'b1;
        drive(0, 2'b00, 0, 0);
        #12;
        chk_all("reset", 32'h3000, 0, 0, 0, 0);
        chk("reset imem_addr", {22'd0, imem_addr}, 0);
        do_reset;

        for (int i = 0; i < 8; i++) begin
            drive(tv[i].stall, tv[i].sel, tv[i].bt, tv[i].rs);
            edge1;
            chk_all($sformatf("vec%0d", i), tv[i].pc, tv[i].ir,
                    tv[i].pc4, tv[i].pc8, tv[i].cnt);
        end

        // j / jal with a two-cycle stall in front of it
        rom[1] = JMP;
        drive(0, 2'b00, 0, 0);
        do_reset;
        edge1;
        edge1;
        chk_all("j in D", 32'h3008, JMP, 32'h3008, 32'h300C, 2);
        drive(1, 2'b10, 0, 32'h1234);
        edge1;
        chk_all("stall1", 32'h3008, JMP, 32'h3008, 32'h300C, 2);
        edge1;
        chk_all("stall2", 32'h3008, JMP, 32'h3008, 32'h300C, 2);
        drive(0, 2'b10, 0, 0);
        edge1;
        chk_all("j taken", 32'h3040, W2, 32'h300C, 32'h3010, 3);
        chk("j imem_addr", {22'd0, imem_addr}, 32'h10);

        // jr, including a misaligned target
        drive(0, 2'b11, 0, 32'h3100);
        edge1;
        chk_all("jr", 32'h3100, W10, 32'h3044, 32'h3048, 4);
        chk("jr imem_addr", {22'd0, imem_addr}, 32'h40);
        drive(0, 2'b11, 0, 32'h3102);
        edge1;
        chk_all("jr mis", 32'h3102, W40, 32'h3104, 32'h3108, 5);
        chk("jr mis imem_addr", {22'd0, imem_addr}, 32'h40);
        drive(0, 2'b11, 0, 32'h3100);
        edge1;
        chk_all("jr back", 32'h3100, W40, 32'h3106, 32'h310A, 6);

        // async reset mid-cycle, seen before any clock edge
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async rst", 32'h3000, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // 32-bit wrap of pc and address wrap
        drive(0, 2'b11, 0, 32'hFFFF_FFFC);
        edge1;
        chk("wrap pc", pc, 32'hFFFF_FFFC);
        chk("wrap imem_addr hi", {22'd0, imem_addr}, 32'h3FF);
        drive(0, 2'b00, 0, 0);
        edge1;
        chk_all("wrap seq", 32'h0, rom[10'h3FF], 32'h0, 32'h4, 2);
        chk("wrap imem_addr lo", {22'd0, imem_addr}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC, addresses the instruction memory, and latches {instruction, PC+4, PC+8} into the F/D register.
- Its fd_ir output is the D-stage instruction word that the hazard unit decodes.
- Consumes the hazard unit's stall, plus next-PC select, branch decision and forwarded rs from the D stage.
- Branches and jumps have one delay slot.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset; also the base address of instruction memory.
IMEM_AW, 10, instruction-memory word-address width (1024 words).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  from hazard unit; freeze PC and F/D
npc_sel  input  2  00 seq, 01 branch, 10 j/jal, 11 jr (driven for the D-stage instruction)
branch_taken  input  1  D-stage comparator result; used only when npc_sel=01
rs_fwd  input  32  forwarded GPR[rs] (after FRSD mux), jr target
imem_addr  output  IMEM_AW  word index into instruction ROM
imem_rdata  input  32  combinational ROM data for imem_addr
pc  output  32  current F-stage PC
fd_ir  output  32  D-stage instruction
fd_pc4  output  32  PC+4 of D-stage instruction
fd_pc8  output  32  PC+8 of D-stage instruction (link value for jal)
fetch_cnt  output  32  number of F/D loads since reset

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately, including mid-operation. Reset values: pc=PC_RESET, fd_ir=0 (nop), fd_pc4=0, fd_pc8=0, fetch_cnt=0.
- imem_addr = (pc - PC_RESET)[IMEM_AW+1:2], combinational. pc[1:0] is ignored for addressing.
- Address wrap: out-of-range addresses wrap modulo 2^IMEM_AW words. No fault is raised.
- Targets are computed from the F/D contents:
  - seq = pc + 4
  - br = fd_pc4 + (sign-extend(fd_ir[15:0]) << 2)
  - jt = {fd_pc4[31:28], fd_ir[25:0], 2'b00}
  - jrt = rs_fwd
- Next-PC selection:
  - npc_sel=00 -> seq
  - npc_sel=01 -> br if branch_taken else seq
  - npc_sel=10 -> jt
  - npc_sel=11 -> jrt
- Rising edge with stall=0:
  - pc <= next-PC
  - fd_ir <= imem_rdata
  - fd_pc4 <= pc+4
  - fd_pc8 <= pc+8
  - fetch_cnt <= fetch_cnt+1
- Delay slot: the instruction fetched in the same cycle a branch/jump is in D is latched normally. No flush.
- Rising edge with stall=1: pc, fd_ir, fd_pc4, fd_pc8 and fetch_cnt all hold.
  - npc_sel and branch_taken are ignored; the D-stage control transfer is re-evaluated on the un-stalled cycle.
  - Stall has priority over every redirect.
- Latency: the first instruction (at PC_RESET) appears on fd_ir one edge after reset deassertion. A redirect takes effect on pc at the same edge that latches the delay slot.
- Arithmetic is 32-bit modulo:
  - pc+4 from 32'hFFFF_FFFC yields 0.
  - fetch_cnt wraps from 32'hFFFF_FFFF to 0.
  - Branch offset addition is modulo 2^32.
- Misaligned jr target: pc is loaded exactly as given, low bits included. fd_pc4/fd_pc8 carry the low bits through. imem_addr ignores them.
- All state updates are in one clocked process. Target/next-PC/address logic is combinational. There are no other state elements.

Test Plan:
- Reset release, stall=0, npc_sel=00, ROM words 0..3 distinct:
  - pc steps 0x3000, 0x3004, 0x3008.
  - fd_ir follows ROM[0], ROM[1] one edge later.
  - fd_pc4=0x3004 then 0x3008; fd_pc8=0x3008 then 0x300C.
  - fetch_cnt=1, 2, 3.
- beq in D at 0x3004, offset 16'hFFFF, npc_sel=01, branch_taken=1:
  - next pc=0x3004 (0x3008-4).
  - Delay-slot word ROM[2] latched into fd_ir.
  - Same setup with branch_taken=0 -> pc=0x300C.
- j in D, fd_ir=32'h0800_0C10, fd_pc4=0x3008, npc_sel=10 -> next pc=0x0000_3040. jal: fd_pc8 of the jal equals 0x300C.
- jr with rs_fwd=0x0000_3100, npc_sel=11:
  - pc=0x3100 and imem_addr=0x40.
  - rs_fwd=0x3102 -> pc=0x3102, imem_addr still 0x40.
- stall held 2 cycles while npc_sel=10:
  - pc, fd_ir, fd_pc4, fd_pc8 and fetch_cnt unchanged for both edges.
  - On release, the jump is taken using the then-current inputs.
- Assert reset asynchronously mid-cycle while pc=0x3100 -> pc=0x3000, fd_ir=0 and fetch_cnt=0 immediately, before the next clk edge.
